conv_upsize: RTL and testbench

CONV_UPSIZE -- requirements
Module: conv_upsize

---
 rtl/conv_upsize_pkg.sv | 24 ++
 rtl/conv_upsize.sv | 109 ++++++++++
 tb/tb_conv_upsize.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_upsize_pkg.sv
// -----------------------------------------------------------------------------
// conv_upsize_pkg
// Shared helpers for the width converters: the allowed RATIO range and the
// beat-to-lane mapping. Imported by conv_upsize.
// -----------------------------------------------------------------------------
package conv_upsize_pkg;

  localparam int unsigned RATIO_MIN = 2;
  localparam int unsigned RATIO_MAX = 16;

  // True when the beats-per-word ratio is one the converters support.
  function automatic bit ratio_ok(input int unsigned ratio);
    return (ratio >= RATIO_MIN) && (ratio <= RATIO_MAX);
  endfunction

  // Lane that beat number 'beat' occupies in the wide word.
  // msb_first=1: beat 0 goes to the top lane; msb_first=0: beat 0 to lane 0.
  function automatic int unsigned lane_idx(input int unsigned beat,
                                           input int unsigned ratio,
                                           input bit          msb_first);
    return msb_first ? (ratio - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/conv_upsize.sv
// -----------------------------------------------------------------------------
// conv_upsize
// Packs RATIO narrow beats of IN_W bits into one wide word. The first
// RATIO-1 beats of a word are captured in lane registers; the closing beat
// (last beat of a word, or any beat with last_in) passes straight through
// combinationally together with the stored lanes, so the wide word is
// presented in the same cycle as the closing beat.
//
// Ports
//   clk_in     : clock, all state changes on the rising edge
//   reset_in   : synchronous active-high reset
//   data_in    : narrow beat            valid_in  : beat valid
//   last_in    : beat ends the packet   ready_out : beat accepted this cycle
//   data_out   : wide word, lane i = [i*IN_W +: IN_W]
//   keep_out   : per-lane "holds real data"
//   last_out   : word ends the packet   valid_out : wide word valid
//   ready_in   : downstream accepts the wide word
// -----------------------------------------------------------------------------
module conv_upsize
  import conv_upsize_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO     = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [IN_W-1:0]       data_in,
  input  logic                  valid_in,
  input  logic                  last_in,
  output logic                  ready_out,
  output logic [IN_W*RATIO-1:0] data_out,
  output logic [RATIO-1:0]      keep_out,
  output logic                  last_out,
  output logic                  valid_out,
  input  logic                  ready_in
);

  if (!ratio_ok(RATIO)) begin : g_bad_ratio
    $error("conv_upsize: RATIO=%0d outside supported range 2..16", RATIO);
  end

  localparam int unsigned         CNT_W   = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  lane_q [RATIO-1];   // indexed by beat number, not lane
  logic             lane_we;
  logic             closing;

  assign closing  = (cnt_q == CNT_MAX) || last_in;
  assign last_out = last_in && closing;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q;
    lane_we   = 1'b0;
    ready_out = 1'b0;
    valid_out = 1'b0;
    if (!reset_in) begin
      if (closing) begin
        // Closing beat: handshake is a straight pass-through.
        ready_out = ready_in;
        valid_out = valid_in;
        if (valid_in && ready_in) cnt_d = '0;
      end else begin
        // Filling beats never wait on the downstream side.
        ready_out = 1'b1;
        if (valid_in) begin
          cnt_d   = cnt_q + CNT_W'(1);
          lane_we = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from the same pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // NOTE: lane registers carry no reset; their content is only ever read for
  // beats below cnt, which reset clears, so a reset would buy nothing.
  always_ff @(posedge clk_in) begin
    for (int k = 0; k < int'(RATIO) - 1; k++) begin
      if (lane_we && (cnt_q == CNT_W'(k))) lane_q[k] <= data_in;
    end
  end

  // Output mux: for beat k, stored beats come from registers, the current
  // beat from data_in, beats not yet reached read as zero.
  for (genvar k = 0; k < RATIO; k++) begin : g_beat
    localparam int unsigned      LANE = lane_idx(k, RATIO, MSB_FIRST);
    localparam logic [CNT_W-1:0] K    = CNT_W'(k);

    if (k < RATIO - 1) begin : g_reg
      assign data_out[LANE*IN_W +: IN_W] = (cnt_q > K)  ? lane_q[k] :
                                           (cnt_q == K) ? data_in   : '0;
    end else begin : g_top
      assign data_out[LANE*IN_W +: IN_W] = (cnt_q == K) ? data_in : '0;
    end

    assign keep_out[LANE] = (cnt_q >= K);
  end

endmodule

// File: tb/tb_conv_upsize.sv
// -----------------------------------------------------------------------------
// tb_conv_upsize
// Directed bench for conv_upsize with three configurations:
//   a : defaults (IN_W=8, RATIO=2, MSB_FIRST=1)
//   b : RATIO=4, MSB_FIRST=0
//   c : RATIO=4, MSB_FIRST=1
// Inputs change 1 ns after the rising edge; outputs are sampled 4 ns later.
// -----------------------------------------------------------------------------
module tb_conv_upsize;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  // ---------------- DUT a: defaults ----------------
  logic        a_rst, a_valid, a_last, a_rdy_in;
  logic [7:0]  a_data;
  logic        a_rdy_out, a_last_out, a_valid_out;
  logic [15:0] a_dout;
  logic [1:0]  a_keep;

  conv_upsize dut_a (
    .clk_in(clk), .reset_in(a_rst), .data_in(a_data), .valid_in(a_valid),
    .last_in(a_last), .ready_out(a_rdy_out), .data_out(a_dout),
    .keep_out(a_keep), .last_out(a_last_out), .valid_out(a_valid_out),
    .ready_in(a_rdy_in)
  );

  // ---------------- DUT b: RATIO=4, LSB first ----------------
  logic        b_rst, b_valid, b_last, b_rdy_in;
  logic [7:0]  b_data;
  logic        b_rdy_out, b_last_out, b_valid_out;
  logic [31:0] b_dout;
  logic [3:0]  b_keep;

  conv_upsize #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) dut_b (
    .clk_in(clk), .reset_in(b_rst), .data_in(b_data), .valid_in(b_valid),
    .last_in(b_last), .ready_out(b_rdy_out), .data_out(b_dout),
    .keep_out(b_keep), .last_out(b_last_out), .valid_out(b_valid_out),
    .ready_in(b_rdy_in)
  );

  // ---------------- DUT c: RATIO=4, MSB first ----------------
  logic        c_rst, c_valid, c_last, c_rdy_in;
  logic [7:0]  c_data;
  logic        c_rdy_out, c_last_out, c_valid_out;
  logic [31:0] c_dout;
  logic [3:0]  c_keep;

  conv_upsize #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1)) dut_c (
    .clk_in(clk), .reset_in(c_rst), .data_in(c_data), .valid_in(c_valid),
    .last_in(c_last), .ready_out(c_rdy_out), .data_out(c_dout),
    .keep_out(c_keep), .last_out(c_last_out), .valid_out(c_valid_out),
    .ready_in(c_rdy_in)
  );

  initial begin
    int unsigned vcount;
    logic [7:0]  b_beats [8];

    a_rst = 1'b1; a_valid = 1'b0; a_last = 1'b0; a_rdy_in = 1'b1; a_data = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_last = 1'b0; b_rdy_in = 1'b1; b_data = '0;
    c_rst = 1'b1; c_valid = 1'b0; c_last = 1'b0; c_rdy_in = 1'b1; c_data = '0;

    // Reset: handshake outputs forced low even with valid_in high.
    tick();
    a_valid = 1'b1; a_data = 8'hEE;
    settle();
    check("a_rst_ready", a_rdy_out, 0);
    check("a_rst_valid", a_valid_out, 0);
    tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // ---- a: 0x12, 0x34 with ready_in=1 ----
    a_data = 8'h12; a_valid = 1'b1;
    settle();
    check("a1_valid", a_valid_out, 0);
    check("a1_ready", a_rdy_out, 1);
    tick();
    a_data = 8'h34;
    settle();
    check("a2_valid", a_valid_out, 1);
    check("a2_data",  a_dout, 16'h1234);
    check("a2_keep",  a_keep, 2'b11);
    check("a2_last",  a_last_out, 0);
    tick();

    // ---- a: 0x56, 0x78 with downstream stalled 2 cycles ----
    a_data = 8'h56; a_rdy_in = 1'b0;
    settle();
    check("a3_ready_nc", a_rdy_out, 1);
    tick();
    a_data = 8'h78;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("a4_stall_ready", a_rdy_out, 0);
      check("a4_stall_valid", a_valid_out, 1);
      check("a4_stall_data",  a_dout, 16'h5678);
      tick();
    end
    a_rdy_in = 1'b1;
    settle();
    check("a4_go_ready", a_rdy_out, 1);
    check("a4_go_data",  a_dout, 16'h5678);
    tick();
    // cnt back at 0: next beat is a filling beat.
    a_data = 8'h9A;
    settle();
    check("a5_cnt0_valid", a_valid_out, 0);
    check("a5_cnt0_ready", a_rdy_out, 1);
    tick();
    a_data = 8'hBC;
    settle();
    check("a5_data", a_dout, 16'h9ABC);
    tick();

    // ---- a: gaps of 3 idle cycles between beats ----
    a_data = 8'hDE;
    tick();
    a_valid = 1'b0; a_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("a6_gap_valid", a_valid_out, 0);
      tick();
    end
    a_valid = 1'b1; a_data = 8'hAD;
    settle();
    check("a6_valid", a_valid_out, 1);
    check("a6_data",  a_dout, 16'hDEAD);
    check("a6_keep",  a_keep, 2'b11);
    tick();

    // ---- a: last_in on beat 0 ----
    a_data = 8'h77; a_last = 1'b1;
    settle();
    check("a7_valid", a_valid_out, 1);
    check("a7_data",  a_dout, 16'h7700);
    check("a7_keep",  a_keep, 2'b10);
    check("a7_last",  a_last_out, 1);
    tick();
    a_valid = 1'b0; a_last = 1'b0;

    // ---- b: continuous stream, LSB first, 1-in-4 duty cycle ----
    b_beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    vcount  = 0;
    b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_data = b_beats[i];
      settle();
      check("b_ready", b_rdy_out, 1);
      check("b_valid_phase", b_valid_out, (i % 4) == 3);
      if (b_valid_out) vcount++;
      if (i == 3) begin
        check("b_data1", b_dout, 32'h44332211);
        check("b_keep1", b_keep, 4'hF);
      end
      if (i == 7) check("b_data2", b_dout, 32'h88776655);
      tick();
    end
    check("b_duty", vcount, 2);
    // last_in on beat 0 with LSB first lands in lane 0.
    b_data = 8'h5A; b_last = 1'b1;
    settle();
    check("b_single_data", b_dout, 32'h0000005A);
    check("b_single_keep", b_keep, 4'b0001);
    tick();
    b_valid = 1'b0; b_last = 1'b0;

    // ---- c: AA, BB, CC+last -> partial word flushed ----
    c_valid = 1'b1;
    c_data = 8'hAA; tick();
    c_data = 8'hBB; tick();
    c_data = 8'hCC; c_last = 1'b1;
    settle();
    check("c_part_valid", c_valid_out, 1);
    check("c_part_data",  c_dout, 32'hAABBCC00);
    check("c_part_keep",  c_keep, 4'b1110);
    check("c_part_last",  c_last_out, 1);
    tick();
    // Next beat starts a new word in lane 3.
    c_data = 8'hDD;
    settle();
    check("c_next_data", c_dout, 32'hDD000000);
    check("c_next_keep", c_keep, 4'b1000);
    tick();
    c_last = 1'b0;

    // ---- c: reset mid-word discards the partial word ----
    c_data = 8'hF1; tick();
    c_data = 8'hF2; tick();
    c_rst = 1'b1; c_data = 8'hF3;
    settle();
    check("c_rst_valid", c_valid_out, 0);
    check("c_rst_ready", c_rdy_out, 0);
    tick();
    c_rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      c_data = 8'(i);
      settle();
      if (i < 4) check("c_refill_valid", c_valid_out, 0);
      else begin
        check("c_refill_valid", c_valid_out, 1);
        check("c_refill_data",  c_dout, 32'h01020304);
        check("c_refill_keep",  c_keep, 4'hF);
        check("c_refill_last",  c_last_out, 0);
      end
      tick();
    end
    c_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
